flow_meta_rx: RTL and testbench

FLOW_META_RX -- requirements
Module: flow_meta_rx

---
 rtl/flow_meta_rx.sv | 84 ++++++++
 tb/tb_flow_meta_rx.sv | 184 ++++++++++++++++++
 2 files changed

// File: rtl/flow_meta_rx.sv
// rtl/flow_meta_rx.sv - first-word fall-through metadata buffer with registered input ready.
// Optional saturating input statistics are enabled by defining FLOW_META_RX_STATS_EN.
module flow_meta_rx #(
  parameter int DEPTH  = 8,
  parameter int META_W = 32
) (
  input  logic              i_clk,
  input  logic              i_rst,
  input  logic [META_W-1:0] i_in_meta_data,
  input  logic              i_in_meta_valid,
  output logic              o_in_meta_ready,
  output logic [META_W-1:0] o_out_meta_data,
  output logic              o_out_meta_valid,
  input  logic              i_out_meta_ready,
  output logic [31:0]       o_stat_accepted,
  output logic [31:0]       o_stat_stalled
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
  localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);

  logic [META_W-1:0] r_mem [DEPTH];
  logic [AW-1:0]     r_wr_ptr;
  logic [AW-1:0]     r_rd_ptr;
  logic [CW-1:0]     r_count;
  logic              r_in_ready;

  logic              w_push;
  logic              w_pop;
  logic [CW-1:0]     w_count_next;

  assign w_push       = i_in_meta_valid & r_in_ready;
  assign w_pop        = (r_count != '0) & i_out_meta_ready;
  assign w_count_next = r_count + CW'(w_push) - CW'(w_pop);

  // Ready is precomputed from next occupancy so it never combinationally follows the consumer.
  always_ff @(posedge i_clk or negedge i_rst) begin
    if (!i_rst) begin
      r_wr_ptr   <= '0;
      r_rd_ptr   <= '0;
      r_count    <= '0;
      r_in_ready <= 1'b0;
    end else begin
      if (w_push) r_wr_ptr <= r_wr_ptr + AW'(1);
      if (w_pop)  r_rd_ptr <= r_rd_ptr + AW'(1);
      r_count    <= w_count_next;
      r_in_ready <= (w_count_next < DEPTH_C);
    end
  end

  always_ff @(posedge i_clk) begin
    if (w_push) r_mem[r_wr_ptr] <= i_in_meta_data;
  end

  assign o_in_meta_ready  = r_in_ready;
  assign o_out_meta_valid = (r_count != '0);
  assign o_out_meta_data  = r_mem[r_rd_ptr];

`ifdef FLOW_META_RX_STATS_EN
  logic [31:0] r_stat_accepted;
  logic [31:0] r_stat_stalled;
  logic        w_stall;

  assign w_stall = i_in_meta_valid & ~r_in_ready;

  always_ff @(posedge i_clk or negedge i_rst) begin
    if (!i_rst) begin
      r_stat_accepted <= '0;
      r_stat_stalled  <= '0;
    end else begin
      if (w_push && (r_stat_accepted != '1)) r_stat_accepted <= r_stat_accepted + 32'd1;
      if (w_stall && (r_stat_stalled != '1)) r_stat_stalled <= r_stat_stalled + 32'd1;
    end
  end

  assign o_stat_accepted = r_stat_accepted;
  assign o_stat_stalled  = r_stat_stalled;
`else
  assign o_stat_accepted = '0;
  assign o_stat_stalled  = '0;
`endif

endmodule

// File: tb/tb_flow_meta_rx.sv
// tb/tb_flow_meta_rx.sv - scoreboard bench for flow_meta_rx (DEPTH=8, 32-bit metadata).
module tb_flow_meta_rx;

`ifdef FLOW_META_RX_STATS_EN
  localparam int STATS = 1;
`else
  localparam int STATS = 0;
`endif

  logic        clk;
  logic        rst;
  logic [31:0] in_data;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] out_data;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] stat_acc;
  logic [31:0] stat_stall;

  int checks   = 0;
  int failures = 0;
  int pops     = 0;
  logic [31:0] exp_q[$];

  flow_meta_rx #(.DEPTH(8), .META_W(32)) dut (
    .i_clk           (clk),
    .i_rst           (rst),
    .i_in_meta_data  (in_data),
    .i_in_meta_valid (in_valid),
    .o_in_meta_ready (in_ready),
    .o_out_meta_data (out_data),
    .o_out_meta_valid(out_valid),
    .i_out_meta_ready(out_ready),
    .o_stat_accepted (stat_acc),
    .o_stat_stalled  (stat_stall)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  // Monitor: a pop happens at the next rising edge whenever valid & ready are seen here.
  always @(negedge clk) begin
    if (rst && out_valid && out_ready) begin
      checks++;
      if (exp_q.size() == 0) begin
        failures++;
        $display("FAIL sb_unexpected actual=%0h required=none", out_data);
      end else begin
        logic [31:0] e;
        e = exp_q.pop_front();
        if (out_data !== e) begin
          failures++;
          $display("FAIL sb_data actual=%0h required=%0h", out_data, e);
        end
      end
      pops++;
    end
  end

  // Called at posedge+1; drives one cycle, records the handshake, returns at next posedge+1.
  task automatic step(input logic v, input logic [31:0] d, input logic r, output logic acc);
    in_valid  = v;
    in_data   = d;
    out_ready = r;
    @(negedge clk);
    acc = v && in_ready;
    if (acc) exp_q.push_back(d);
    @(posedge clk);
    #1;
  endtask

  task automatic drain(input string name);
    logic a;
    int n;
    n = 0;
    while (out_valid && n < 40) begin
      step(1'b0, 32'h0, 1'b1, a);
      n++;
    end
    out_ready = 1'b0;
    chk({name, "_drained"}, {31'd0, out_valid}, 32'd0);
    chk({name, "_q_empty"}, exp_q.size(), 32'd0);
  endtask

  initial begin
    logic acc;
    int   sent;
    int   cyc;
    int   p0;

    rst = 1'b0; in_valid = 1'b0; in_data = '0; out_ready = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_ready", {31'd0, in_ready}, 32'd0);
    chk("rst_valid", {31'd0, out_valid}, 32'd0);
    chk("rst_stat_acc", stat_acc, 32'd0);
    chk("rst_stat_stall", stat_stall, 32'd0);
    rst = 1'b1;
    @(negedge clk);
    chk("ready_before_first_edge", {31'd0, in_ready}, 32'd0);
    @(posedge clk);
    #1;
    chk("ready_after_first_edge", {31'd0, in_ready}, 32'd1);

    // Back-to-back A,B,C with consumer always ready.
    step(1'b1, 32'hA, 1'b1, acc);
    chk("abc_lat_valid", {31'd0, out_valid}, 32'd1);
    chk("abc_lat_data", out_data, 32'hA);
    chk("abc_ready0", {31'd0, in_ready}, 32'd1);
    step(1'b1, 32'hB, 1'b1, acc);
    chk("abc_ready1", {31'd0, in_ready}, 32'd1);
    step(1'b1, 32'hC, 1'b1, acc);
    chk("abc_ready2", {31'd0, in_ready}, 32'd1);
    drain("abc");
    chk("abc_stat_acc", stat_acc, STATS ? 32'd3 : 32'd0);

    // Fill with consumer stalled for 10 cycles.
    for (int i = 0; i < 10; i++) begin
      step(1'b1, 32'h10 + i, 1'b0, acc);
      chk("fill_hold_data", out_data, 32'h10);
    end
    chk("fill_ready_low", {31'd0, in_ready}, 32'd0);
    chk("fill_accepted", exp_q.size(), 32'd8);
    chk("fill_stat_acc", stat_acc, STATS ? 32'd11 : 32'd0);
    chk("fill_stat_stall", stat_stall, STATS ? 32'd2 : 32'd0);

    // One pop from full, then refill to full.
    step(1'b1, 32'h99, 1'b1, acc);
    chk("full_pop_no_push", {31'd0, acc}, 32'd0);
    chk("full_pop_ready", {31'd0, in_ready}, 32'd1);
    step(1'b1, 32'h99, 1'b0, acc);
    chk("refill_accepted", {31'd0, acc}, 32'd1);
    chk("refill_ready_low", {31'd0, in_ready}, 32'd0);
    chk("refill_stat_acc", stat_acc, STATS ? 32'd12 : 32'd0);
    chk("refill_stat_stall", stat_stall, STATS ? 32'd3 : 32'd0);
    drain("refill");

    // 1000 sequence-numbered beats under random valid/ready.
    sent = 0; cyc = 0; p0 = pops;
    while (sent < 1000 && cyc < 20000) begin
      step(($urandom_range(0, 3) != 0), sent, ($urandom_range(0, 2) != 0), acc);
      if (acc) sent++;
      cyc++;
    end
    chk("rand_sent", sent, 32'd1000);
    drain("rand");
    chk("rand_pops", pops - p0, 32'd1000);

    // Asynchronous reset with 5 beats buffered.
    for (int i = 0; i < 5; i++) step(1'b1, 32'h50 + i, 1'b0, acc);
    chk("pre_rst_valid", {31'd0, out_valid}, 32'd1);
    in_valid = 1'b0;
    #2;
    rst = 1'b0;
    #1;
    chk("async_rst_valid", {31'd0, out_valid}, 32'd0);
    chk("async_rst_ready", {31'd0, in_ready}, 32'd0);
    chk("async_rst_stat_acc", stat_acc, 32'd0);
    chk("async_rst_stat_stall", stat_stall, 32'd0);
    exp_q.delete();
    @(posedge clk);
    #1;
    rst = 1'b1;
    step(1'b0, 32'h0, 1'b1, acc);
    p0 = pops;
    step(1'b1, 32'hABCD, 1'b1, acc);
    chk("post_rst_accept", {31'd0, acc}, 32'd1);
    drain("post_rst");
    chk("post_rst_pops", pops - p0, 32'd1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
